// File: rtl/fetch_queue_pkg.sv
// Shared pipeline definitions for the instruction fetch queue: entry type,
// NOP bubble and queue state encoding.
package fetch_queue_pkg;

    localparam int XLEN     = 32;
    localparam int FQ_DEPTH = 4;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_next;
        logic            exc_req;
        logic [3:0]      exc_code;
        logic            irq_req;
    } type_fq_entry_s;

    localparam type_fq_entry_s FQ_NOP = '{
        instr:    INSTR_NOP,
        pc:       '0,
        pc_next:  '0,
        exc_req:  1'b0,
        exc_code: 4'h0,
        irq_req:  1'b0
    };

    typedef enum logic {
        FQ_RUN  = 1'b0,
        FQ_HOLD = 1'b1
    } type_fq_state_e;

    // An entry carrying an exception or interrupt stops fetch behind it.
    function automatic logic fq_is_fault(input type_fq_entry_s e);
        return e.exc_req | e.irq_req;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle around the fetch queue; master is the
// pipeline side, slave is the queue.
interface fetch_queue_if #(
    parameter int DEPTH = fetch_queue_pkg::FQ_DEPTH
);
    logic                                enq_valid;
    logic                                enq_ready;
    fetch_queue_pkg::type_fq_entry_s     enq_entry;
    logic                                deq_valid;
    logic                                deq_ready;
    fetch_queue_pkg::type_fq_entry_s     deq_entry;
    logic                                flush;
    logic [$clog2(DEPTH):0]              count;
    logic                                fault_hold;

    modport master (
        output enq_valid, enq_entry, deq_ready, flush,
        input  enq_ready, deq_valid, deq_entry, count, fault_hold
    );

    modport slave (
        input  enq_valid, enq_entry, deq_ready, flush,
        output enq_ready, deq_valid, deq_entry, count, fault_hold
    );

endinterface

// File: rtl/fetch_queue_ptr_ctrl.sv
// Pointer, occupancy and RUN/HOLD control for the fetch queue; the entry
// storage itself lives in the top module.
module fq_ptr_ctrl
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = FQ_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enq_valid,
    input  logic          enq_fault,
    input  logic          deq_ready,
    input  logic          flush,
    output logic          enq_ready,
    output logic          deq_valid,
    output logic          wr_en,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          fault_hold
);

    type_fq_state_e state_q, state_d;
    logic           full, empty, enq_fire, deq_fire;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign fault_hold = (state_q == FQ_HOLD);

    // Ready is independent of deq_ready so decode never reaches fetch combinationally.
    assign enq_ready = ~full & ~fault_hold & ~flush;
    assign deq_valid = ~empty & ~flush;
    assign enq_fire  = enq_valid & enq_ready;
    assign deq_fire  = deq_valid & deq_ready;
    assign wr_en     = enq_fire;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            state_q <= FQ_RUN;
        end else begin
            state_q <= state_d;
            if (enq_fire) wr_ptr <= wr_ptr + AW'(1);
            if (deq_fire) rd_ptr <= rd_ptr + AW'(1);
            unique case ({enq_fire, deq_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: next-state gets its default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FQ_RUN:  if (enq_fire && enq_fault) state_d = FQ_HOLD;
            FQ_HOLD: if (flush)                 state_d = FQ_RUN;
            default:                            state_d = FQ_RUN;
        endcase
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of fetched entries between fetch
// and decode, flushed in one cycle on redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = FQ_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_queue_if.slave   bus
);

    logic           wr_en;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    type_fq_entry_s entries [DEPTH];

    fq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .enq_valid  (bus.enq_valid),
        .enq_fault  (fq_is_fault(bus.enq_entry)),
        .deq_ready  (bus.deq_ready),
        .flush      (bus.flush),
        .enq_ready  (bus.enq_ready),
        .deq_valid  (bus.deq_valid),
        .wr_en      (wr_en),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .count      (bus.count),
        .fault_hold (bus.fault_hold)
    );

    // NOTE: the entry array has no reset; an empty queue shows the NOP bubble,
    // so stale contents are never visible and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) entries[wr_ptr] <= bus.enq_entry;
    end

    assign bus.deq_entry = bus.deq_valid ? entries[rd_ptr] : FQ_NOP;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based scoreboard predicts
// handshakes, occupancy, fault hold and the head entry every cycle.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    fetch_queue_if #(.DEPTH(DEPTH)) fq_bus ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fq_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int dut_pops = 0;

    type_fq_entry_s exp_q[$];
    logic           m_hold = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic type_fq_entry_s mk(input logic [31:0] pc, input logic exc,
                                          input logic [3:0] code, input logic irq);
        type_fq_entry_s e;
        e.instr    = pc ^ 32'h00A5_0093;
        e.pc       = pc;
        e.pc_next  = pc + 32'd4;
        e.exc_req  = exc;
        e.exc_code = code;
        e.irq_req  = irq;
        return e;
    endfunction

    // One cycle: drive at the falling edge, check before the rising edge,
    // then advance the scoreboard with the handshakes the model predicts.
    task automatic step(input logic ev, input type_fq_entry_s e, input logic dr, input logic fl);
        logic x_rdy, x_dv;
        int   m_count;
        fq_bus.enq_valid = ev;
        fq_bus.enq_entry = e;
        fq_bus.deq_ready = dr;
        fq_bus.flush     = fl;
        #1;
        m_count = exp_q.size();
        x_rdy   = (m_count != DEPTH) && !m_hold && !fl;
        x_dv    = (m_count != 0) && !fl;
        check("enq_ready",  fq_bus.enq_ready,  x_rdy);
        check("deq_valid",  fq_bus.deq_valid,  x_dv);
        check("count",      fq_bus.count,      m_count);
        check("fault_hold", fq_bus.fault_hold, m_hold);
        check("deq_entry",  fq_bus.deq_entry,  x_dv ? exp_q[0] : FQ_NOP);
        if (fq_bus.deq_valid && dr) dut_pops++;
        if (fl) begin
            exp_q.delete();
            m_hold = 1'b0;
        end else begin
            if (x_dv && dr) void'(exp_q.pop_front());
            if (ev && x_rdy) begin
                exp_q.push_back(e);
                if (e.exc_req || e.irq_req) m_hold = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic dr);
        step(1'b0, mk(32'h0, 1'b0, 4'h0, 1'b0), dr, 1'b0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        fq_bus.enq_valid = 1'b0;
        fq_bus.deq_ready = 1'b0;
        fq_bus.flush     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_hold = 1'b0;
    endtask

    initial begin
        int pops0;
        rst_n            = 1'b0;
        fq_bus.enq_valid = 1'b0;
        fq_bus.enq_entry = FQ_NOP;
        fq_bus.deq_ready = 1'b0;
        fq_bus.flush     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset values.
        idle(1'b1);

        // Fill to full with decode stalled, push once more, then drain in order.
        for (int i = 0; i < 4; i++) step(1'b1, mk(32'h8000_0000 + 32'(4*i), 1'b0, 4'h0, 1'b0), 1'b0, 1'b0);
        step(1'b1, mk(32'h8000_0010, 1'b0, 4'h0, 1'b0), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b1);

        // Streaming at full throughput; pointers wrap 5 times.
        pops0 = dut_pops;
        for (int i = 0; i < 20; i++) step(1'b1, mk(32'h0000_1000 + 32'(4*i), 1'b0, 4'h0, 1'b0), 1'b1, 1'b0);
        idle(1'b1);
        check("stream_pops", dut_pops - pops0, 20);

        // Flush beats a simultaneous enqueue and dequeue.
        for (int i = 0; i < 3; i++) step(1'b1, mk(32'h0000_2000 + 32'(4*i), 1'b0, 4'h0, 1'b0), 1'b0, 1'b0);
        step(1'b1, mk(32'h0000_2100, 1'b0, 4'h0, 1'b0), 1'b1, 1'b1);
        idle(1'b1);
        step(1'b1, mk(32'h0000_2200, 1'b0, 4'h0, 1'b0), 1'b0, 1'b0);
        idle(1'b1);

        // Faulting entry behind two normal ones holds fetch until flush.
        step(1'b1, mk(32'h0000_3000, 1'b0, 4'h0, 1'b0), 1'b0, 1'b0);
        step(1'b1, mk(32'h0000_3004, 1'b0, 4'h0, 1'b0), 1'b0, 1'b0);
        step(1'b1, mk(32'h0000_3008, 1'b1, 4'd12, 1'b0), 1'b0, 1'b0);
        step(1'b1, mk(32'h0000_300C, 1'b0, 4'h0, 1'b0), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, mk(32'h0000_3100, 1'b0, 4'h0, 1'b0), 1'b1, 1'b0);
        idle(1'b1);
        step(1'b0, mk(32'h0, 1'b0, 4'h0, 1'b0), 1'b0, 1'b1);
        idle(1'b0);
        // An interrupt-flagged entry holds too.
        step(1'b1, mk(32'h0000_3200, 1'b0, 4'h0, 1'b1), 1'b0, 1'b0);
        step(1'b1, mk(32'h0000_3204, 1'b0, 4'h0, 1'b0), 1'b1, 1'b0);
        step(1'b0, mk(32'h0, 1'b0, 4'h0, 1'b0), 1'b0, 1'b1);

        // Full with both sides active: no enqueue this cycle, ready the next.
        for (int i = 0; i < 4; i++) step(1'b1, mk(32'h0000_4000 + 32'(4*i), 1'b0, 4'h0, 1'b0), 1'b0, 1'b0);
        step(1'b1, mk(32'h0000_4010, 1'b0, 4'h0, 1'b0), 1'b1, 1'b0);
        step(1'b1, mk(32'h0000_4014, 1'b0, 4'h0, 1'b0), 1'b1, 1'b0);
        step(1'b1, mk(32'h0000_4018, 1'b0, 4'h0, 1'b0), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Reset mid-operation at count 3, then a fresh entry one cycle later.
        for (int i = 0; i < 3; i++) step(1'b1, mk(32'h0000_5000 + 32'(4*i), 1'b0, 4'h0, 1'b0), 1'b0, 1'b0);
        pulse_reset();
        idle(1'b0);
        step(1'b1, mk(32'h0000_6000, 1'b0, 4'h0, 1'b0), 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the fetch stage and the decode stage. Buffers up to DEPTH fetched instruction entries (instruction word, PC, predicted next PC, exception and interrupt flags) so an instruction-cache hit is not lost when decode stalls. It also absorbs fetch bubbles in front of decode. It flushes in one cycle on any redirect from the execute stage or the CSR unit.

## Interface
- DEPTH, 4: number of entries; power of two, from 2 to 16.
- XLEN, 32: address width.
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- enq_valid  in  1  fetch presents a valid entry.
- enq_ready  out  1  queue accepts the entry this cycle.
- enq_entry  in  type_fq_entry_s  {instr[31:0], pc[XLEN-1:0], pc_next[XLEN-1:0], exc_req, exc_code[3:0], irq_req}.
- deq_valid  out  1  head entry valid.
- deq_ready  in  1  decode consumes the head this cycle.
- deq_entry  out  type_fq_entry_s  head entry.
- flush  in  1  redirect (csr_new_pc_req | exe_new_pc_req | wfi_req); discards all entries.
- count  out  $clog2(DEPTH)+1  current occupancy.
- fault_hold  out  1  queue holds a faulting entry; fetch must stop.

## Operation
- Storage: circular buffer of DEPTH entries with wr_ptr and rd_ptr, each $clog2(DEPTH) bits and wrapping modulo DEPTH, plus a count register.
- Enqueue fires on enq_valid & enq_ready. The entry is written at wr_ptr and wr_ptr increments.
- Dequeue fires on deq_valid & deq_ready. rd_ptr increments.
- enq_ready = (count != DEPTH) & ~fault_hold & ~flush.
  - It does not depend on deq_ready, so there is no combinational path from decode to fetch.
- deq_valid = (count != 0) & ~flush.
- deq_entry is the head entry when deq_valid is high.
  - When the queue is empty, deq_entry = NOP bubble: instr 32'h0000_0013, pc 0, pc_next 0, exc_req 0, exc_code 0, irq_req 0.
- Count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged on simultaneous enqueue and dequeue, or when neither occurs.
- fault_hold state machine:
  - RUN -> HOLD when an enqueue fires with exc_req=1 or irq_req=1.
  - HOLD -> RUN on flush only.
  - In HOLD, entries already queued still drain normally. The faulting entry reaches decode in order.
- Flush:
  - Next cycle: rd_ptr = wr_ptr = 0, count = 0, state = RUN.
  - Any enqueue or dequeue in the flush cycle is suppressed, because enq_ready and deq_valid are forced low.
- Reset: rd_ptr, wr_ptr, count = 0; state RUN.
  - Entry storage is not reset and is never observable while empty.

## Timing
- Outputs after reset: enq_ready=1, deq_valid=0, deq_entry=NOP bubble, count=0, fault_hold=0.
- Enqueue-to-dequeue latency is 1 cycle. An entry accepted at edge N appears with deq_valid=1 after edge N; there is no same-cycle bypass.
- Full throughput: one entry in and one out per cycle, sustained for any occupancy from 1 to DEPTH-1.
- When full (count=DEPTH), enq_ready=0 even if deq_ready=1 in the same cycle. enq_ready returns high the cycle after a dequeue.
- When empty, deq_ready is ignored and no pointer moves.
- Wrap-around: the pointers roll from DEPTH-1 to 0 with no bubble.
- fault_hold and enq_ready change in the cycle after the enqueue that caused HOLD.
- Flush has priority over every other event in the same cycle, including reset-free pointer updates.
- Reset mid-operation: contents are discarded and the outputs take their reset values after the next edge.

## Structure
- type_fq_entry_s, the NOP constant (reusing INSTR_NOP) and the default FQ_DEPTH go in the shared pipeline defines package, next to type_if2id_data_s.
- One sub-module is natural: fq_ptr_ctrl.
  - It holds the pointers, count, full/empty logic and the RUN/HOLD FSM.
  - The top module holds the entry array and the output mux.

## Test plan
- Reset, then push 4 entries with pc 0x8000_0000, 0x8000_0004, 0x8000_0008, 0x8000_000C and deq_ready=0 -> count=4, enq_ready=0. Then raise deq_ready for 4 cycles -> PCs come out in order, and count ends at 0 with deq_valid=0 and the NOP bubble on deq_entry.
- Stream 20 entries with enq_valid=deq_ready=1 -> one output per cycle after 1 cycle of latency, count stays 1, the pointers wrap 5 times, no entry is lost or duplicated.
- Fill to 3, then assert flush together with enq_valid and deq_ready -> the next cycle has count=0 and deq_valid=0, and no entry is consumed or written in the flush cycle.
- Enqueue an entry with exc_req=1, exc_code=12 behind 2 normal entries -> fault_hold=1 and enq_ready=0 from the next cycle. All 3 entries drain in order with the fault last. Flush -> fault_hold=0 and enq_ready=1.
- Hold full with deq_ready=1 and enq_valid=1 -> enq_ready=0 in that cycle and 1 in the next, and count never exceeds 4.
- Assert rst_n=0 for one cycle at count=3 -> all outputs return to their reset values, and a following enqueue appears on deq_entry one cycle later.
